m68k_bus_target: RTL

- 68000 bus responder (target) for the CPLD: decodes asynchronous 68000 bus cycles from an external master in a fixed address window and forwards each as one word request to an on-chip backend.
- Returns the backend result with DTACK_n, or BERR_n on backend error or timeout.
- Runs entirely on PI_CLK. The 68000 clock and all bus inputs are oversampled through synchronizers.

---
 rtl/m68k_pkg.sv | 15 +
 rtl/m68k_sync.sv | 28 ++
 rtl/m68k_bus_target.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/m68k_pkg.sv
// m68k_pkg: shared state encoding and timing defaults for the 68000 bus target
package m68k_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_IGNORE, S_STROBE, S_REQ, S_WAIT, S_HOLD, S_RELEASE
  } state_t;
  localparam int RELEASE_CYCLES = 4;
  localparam logic [23:0] DEF_BASE_ADDR = 24'hE80000;
  localparam int DEF_WIN_BITS = 16;
  localparam int DEF_MIN_WAIT = 2;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_SYNC_STAGES = 2;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/m68k_sync.sv
// m68k_sync: multi-bit synchronizer preset to 1, with registered-level edge detect
module m68k_sync #(
  parameter int W = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);
  logic [W-1:0] s_q [STAGES];
  logic [W-1:0] p_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) s_q[i] <= '1;
      p_q <= '1;
    end else begin
      s_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) s_q[i] <= s_q[i-1];
      p_q <= s_q[STAGES-1];
    end
  end
  assign q_o = s_q[STAGES-1];
  assign rise_o = q_o & ~p_q;
  assign fall_o = ~q_o & p_q;
endmodule

// File: rtl/m68k_bus_target.sv
// m68k_bus_target: decodes oversampled 68000 bus cycles in a fixed window into
// single word backend requests and answers with DTACK, or BERR on error/timeout.
module m68k_bus_target
  import m68k_pkg::*;
#(
  parameter logic [23:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int WIN_BITS = DEF_WIN_BITS,
  parameter int MIN_WAIT = DEF_MIN_WAIT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                PI_CLK,
  input  logic                RESET_n,
  input  logic                M68K_CLK,
  input  logic                M68K_AS_n,
  input  logic                M68K_UDS_n,
  input  logic                M68K_LDS_n,
  input  logic                M68K_RW,
  input  logic [23:1]         M68K_A,
  input  logic [15:0]         M68K_D_IN,
  output logic [15:0]         M68K_D_OUT,
  output logic                M68K_D_OE,
  output logic                M68K_DTACK_n,
  output logic                M68K_DTACK_OE,
  output logic                M68K_BERR_n,
  output logic                BE_REQ,
  output logic [WIN_BITS-2:0] BE_ADDR,
  output logic                BE_WE,
  output logic [1:0]          BE_SEL,
  output logic [15:0]         BE_WDATA,
  input  logic                BE_ACK,
  input  logic [15:0]         BE_RDATA,
  input  logic                BE_ERR
);
  localparam logic [7:0] MIN_W = 8'(MIN_WAIT);
  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam int RC_W = $clog2(RELEASE_CYCLES);
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(RELEASE_CYCLES - 1);
  logic clk_lvl_unused, clk_rise, clk_fall;
  logic as_s, as_rise, as_fall;
  logic [1:0] ds_s, ds_rise_unused, ds_fall_unused;
  state_t st_q;
  logic [7:0] ecnt_q, ecnt_d, ecnt_inc;
  logic [RC_W-1:0] rcnt_q;
  logic rw_q, err_q, hit, tmo;
  m68k_sync #(.W(1), .STAGES(SYNC_STAGES)) u_clk_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i(M68K_CLK),
    .q_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall)
  );
  m68k_sync #(.W(1), .STAGES(SYNC_STAGES)) u_as_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i(M68K_AS_n),
    .q_o(as_s), .rise_o(as_rise), .fall_o(as_fall)
  );
  m68k_sync #(.W(2), .STAGES(SYNC_STAGES)) u_ds_sync (
    .clk(PI_CLK), .rst_n(RESET_n), .d_i({M68K_UDS_n, M68K_LDS_n}),
    .q_o(ds_s), .rise_o(ds_rise_unused), .fall_o(ds_fall_unused)
  );
  assign hit = M68K_A[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS];
  assign ecnt_inc = sat_inc8(ecnt_q);
  assign tmo = clk_fall && (ecnt_inc == TMO);
  // Idle keeps the counter at zero so a cycle caught on idle entry starts clean.
  always_comb begin
    ecnt_d = (as_fall || st_q == S_IDLE) ? 8'd0 : clk_fall ? ecnt_inc : ecnt_q;
  end
  always_ff @(posedge PI_CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      st_q <= S_IDLE;
      ecnt_q <= '0;
      rcnt_q <= '0;
      rw_q <= 1'b0;
      err_q <= 1'b0;
      M68K_D_OUT <= '0;
      M68K_D_OE <= 1'b0;
      M68K_DTACK_n <= 1'b1;
      M68K_DTACK_OE <= 1'b0;
      M68K_BERR_n <= 1'b1;
      BE_REQ <= 1'b0;
      BE_ADDR <= '0;
      BE_WE <= 1'b0;
      BE_SEL <= '0;
      BE_WDATA <= '0;
    end else begin
      ecnt_q <= ecnt_d;
      case (st_q)
        S_IDLE: begin
          rcnt_q <= '0;
          if (!as_s) begin
            rw_q <= M68K_RW;
            BE_ADDR <= M68K_A[WIN_BITS-1:1];
            st_q <= hit ? S_STROBE : S_IGNORE;
          end
        end
        S_IGNORE: if (as_rise) st_q <= S_IDLE;
        S_STROBE: begin
          if (as_rise) st_q <= S_RELEASE;
          else if (tmo) begin
            M68K_BERR_n <= 1'b0;
            st_q <= S_HOLD;
          end else if (ds_s != 2'b11) begin
            BE_SEL <= ~ds_s;
            BE_WE <= ~rw_q;
            BE_WDATA <= M68K_D_IN;
            BE_REQ <= 1'b1;
            st_q <= S_REQ;
          end
        end
        // Priority: master abort, then backend ack, then timeout.
        S_REQ: begin
          if (as_rise) begin
            BE_REQ <= 1'b0;
            st_q <= S_RELEASE;
          end else if (BE_ACK) begin
            BE_REQ <= 1'b0;
            M68K_D_OUT <= BE_RDATA;
            err_q <= BE_ERR;
            st_q <= S_WAIT;
          end else if (tmo) begin
            BE_REQ <= 1'b0;
            M68K_BERR_n <= 1'b0;
            st_q <= S_HOLD;
          end
        end
        S_WAIT: begin
          if (as_rise) st_q <= S_RELEASE;
          else if (clk_rise && ecnt_q >= MIN_W) begin
            if (err_q) M68K_BERR_n <= 1'b0;
            else begin
              M68K_DTACK_n <= 1'b0;
              M68K_DTACK_OE <= 1'b1;
              M68K_D_OE <= rw_q;
            end
            st_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (as_rise) begin
            M68K_D_OE <= 1'b0;
            M68K_BERR_n <= 1'b1;
            M68K_DTACK_n <= 1'b1;
            M68K_DTACK_OE <= 1'b1;
            st_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (rcnt_q == RC_LAST) begin
            M68K_DTACK_OE <= 1'b0;
            st_q <= S_IDLE;
          end else rcnt_q <= rcnt_q + 1'b1;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end
endmodule
